// File: rtl/sram_slot_arbiter.sv
// Time-slotted arbiter sharing one async 256Kx16 SRAM between VGA scan-out and the drawing engine.
// Four-slot frame: VGA owns slots 0-1, drawer owns 2-3 (and steals 0-1 when VGA is idle).
module sram_slot_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              iCLK,
  input  logic              reset,
  input  logic              frame_align,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_ack,
  output logic [DATA_W-1:0] drw_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [2:0] {S_IDLE, S_VGA1, S_VGA2, S_DRW1, S_DRW2} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic              dq_oe;
    logic [DATA_W-1:0] dq;
  } pins_t;

  state_t      state, state_nxt;
  logic [1:0]  slot, slot_nxt;
  logic        acc_we, acc_we_nxt;
  pins_t       pins, pins_nxt;
  logic        ack_nxt;

  assign slot_nxt = frame_align ? 2'd0 : slot + 2'd1;

  // State register plus all registered pin/status outputs
  always_ff @(posedge iCLK) begin
    if (reset) begin
      state     <= S_IDLE;
      slot      <= 2'd0;
      acc_we    <= 1'b0;
      pins      <= '{addr: '0, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0, dq: '0};
      vga_data  <= '0;
      vga_valid <= 1'b0;
      drw_ack   <= 1'b0;
      drw_rdata <= '0;
    end else begin
      state     <= state_nxt;
      slot      <= slot_nxt;
      acc_we    <= acc_we_nxt;
      pins      <= pins_nxt;
      drw_ack   <= ack_nxt;
      vga_valid <= (state == S_VGA2);
      if (state == S_VGA2)
        vga_data <= sram_dq;
      if (state == S_DRW2 && !acc_we)
        drw_rdata <= sram_dq;
    end
  end

  // A first-cycle access is dropped on frame_align; the aborting edge issues no new grant.
  always_comb begin
    state_nxt  = S_IDLE;
    acc_we_nxt = acc_we;
    case (state)
      S_VGA1:  state_nxt = frame_align ? S_IDLE : S_VGA2;
      S_DRW1:  state_nxt = frame_align ? S_IDLE : S_DRW2;
      default: begin
        if (slot_nxt == 2'd0 && vga_req) begin
          state_nxt = S_VGA1;
        end else if ((slot_nxt == 2'd0 || slot_nxt == 2'd2) && drw_req) begin
          state_nxt  = S_DRW1;
          acc_we_nxt = drw_we;
        end
      end
    endcase
  end

  // Next pin values; address and write data are latched at grant and held through the access.
  always_comb begin
    pins_nxt       = pins;
    pins_nxt.ce_n  = 1'b1;
    pins_nxt.oe_n  = 1'b1;
    pins_nxt.we_n  = 1'b1;
    pins_nxt.dq_oe = 1'b0;
    ack_nxt        = 1'b0;
    case (state_nxt)
      S_VGA1: begin
        pins_nxt.addr = vga_addr;
        pins_nxt.ce_n = 1'b0;
        pins_nxt.oe_n = 1'b0;
      end
      S_VGA2: begin
        pins_nxt.ce_n = 1'b0;
        pins_nxt.oe_n = 1'b0;
      end
      S_DRW1: begin
        pins_nxt.addr  = drw_addr;
        pins_nxt.dq    = drw_wdata;
        pins_nxt.ce_n  = 1'b0;
        pins_nxt.oe_n  = acc_we_nxt;
        pins_nxt.dq_oe = acc_we_nxt;
      end
      S_DRW2: begin
        pins_nxt.ce_n  = 1'b0;
        pins_nxt.oe_n  = acc_we_nxt;
        pins_nxt.dq_oe = acc_we_nxt;
        pins_nxt.we_n  = ~acc_we_nxt;
        ack_nxt        = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_addr = pins.addr;
  assign sram_ce_n = pins.ce_n;
  assign sram_oe_n = pins.oe_n;
  assign sram_we_n = pins.we_n;
  assign sram_ub_n = pins.ce_n;
  assign sram_lb_n = pins.ce_n;
  assign sram_dq   = pins.dq_oe ? pins.dq : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a behavioural async SRAM model.
module tb_sram_slot_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          iCLK = 1'b0;
  logic          reset = 1'b1;
  logic          frame_align = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          drw_req = 1'b0;
  logic          drw_we = 1'b0;
  logic [AW-1:0] drw_addr = '0;
  logic [DW-1:0] drw_wdata = '0;
  wire  [DW-1:0] vga_data, drw_rdata;
  wire           vga_valid, drw_ack;
  wire  [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  wire           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  int            wr_cnt = 0;

  int tests = 0;
  int fails = 0;
  int exp_slot = 0;

  sram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK(iCLK), .reset(reset), .frame_align(frame_align),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_ack(drw_ack), .drw_rdata(drw_rdata),
    .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #10 iCLK = ~iCLK;

  // SRAM model: drives on read, stores every cycle with ce_n and we_n low
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : {DW{1'bz}};

  always @(posedge iCLK) begin
    if (pre_en) mem[pre_addr] = pre_data;
    else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] = sram_dq;
      wr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_slot = frame_align ? 0 : (exp_slot + 1) % 4;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    do begin step(); n++; end while (exp_slot != s && n < 8);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge iCLK); @(negedge iCLK);
    pre_en = 1'b0;
  endtask

  initial begin
    int wbase, n;
    @(negedge iCLK);
    preload(18'h12345, 16'hBEEF);
    preload(18'h00A5F, 16'h1111);
    preload(18'h000B0, 16'h0000);
    for (int i = 0; i < 4; i++) preload(18'h00100 + 18'(i), 16'hA000 + 16'(i));

    // reset state
    chk("rst_ce_n", sram_ce_n, 1); chk("rst_oe_n", sram_oe_n, 1); chk("rst_we_n", sram_we_n, 1);
    chk("rst_ub_lb", {sram_ub_n, sram_lb_n}, 2'b11); chk("rst_addr", sram_addr, 0);
    chk("rst_dq_z", sram_dq === 16'hzzzz, 1); chk("rst_vga_data", vga_data, 0);
    chk("rst_valid", vga_valid, 0); chk("rst_ack", drw_ack, 0); chk("rst_rdata", drw_rdata, 0);
    reset = 1'b0; exp_slot = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_ce_n", sram_ce_n, 1); chk("idle_dq_z", sram_dq === 16'hzzzz, 1);
      chk("idle_valid", vga_valid, 0);
    end

    // VGA reads
    vga_req = 1'b1; vga_addr = 18'h12345;
    wait_slot(0);
    chk("vga_s0_oe", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001); chk("vga_s0_addr", sram_addr, 18'h12345);
    step(); chk("vga_s1_oe", sram_oe_n, 0); chk("vga_s1_valid", vga_valid, 0);
    step(); chk("vga_s2_valid", vga_valid, 1); chk("vga_s2_data", vga_data, 16'hBEEF); chk("vga_s2_ce", sram_ce_n, 1);
    step(); chk("vga_s3_valid", vga_valid, 0);
    step(); chk("vga_rep_oe", sram_oe_n, 0);
    step(); step(); chk("vga_rep_valid", vga_valid, 1); chk("vga_rep_data", vga_data, 16'hBEEF);

    // drawer write during active display
    drw_req = 1'b1; drw_we = 1'b1; drw_addr = 18'h00A5F; drw_wdata = 16'h0F0F; wbase = wr_cnt;
    wait_slot(2);
    chk("wr_c1_pins", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b011); chk("wr_c1_addr", sram_addr, 18'h00A5F);
    chk("wr_c1_dq", sram_dq, 16'h0F0F); chk("wr_c1_ack", drw_ack, 0);
    step(); chk("wr_c2_we", sram_we_n, 0); chk("wr_c2_ack", drw_ack, 1); chk("wr_c2_dq", sram_dq, 16'h0F0F);
    drw_req = 1'b0;
    step(); chk("wr_end_we", sram_we_n, 1); chk("wr_end_ack", drw_ack, 0);
    chk("wr_vga_addr", sram_addr, 18'h12345); chk("wr_vga_oe", sram_oe_n, 0);
    chk("wr_count", wr_cnt - wbase, 1); chk("wr_mem", mem[18'h00A5F], 16'h0F0F);
    step(); step(); chk("wr_vga_valid", vga_valid, 1); chk("wr_vga_data", vga_data, 16'hBEEF);

    // blanking: 4 streamed drawer reads
    step();
    vga_req = 1'b0; drw_req = 1'b1; drw_we = 1'b0; drw_addr = 18'h00100;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin step(); n++; end while (!drw_ack && n < 8);
      chk("str_ack", drw_ack, 1); chk("str_slot", exp_slot, (i % 2 == 0) ? 1 : 3);
      chk("str_gap", n, (i == 0) ? 2 : 1); chk("str_addr", sram_addr, 18'h00100 + 18'(i));
      if (i == 3) drw_req = 1'b0; else drw_addr = 18'h00100 + 18'(i + 1);
      step(); chk("str_rdata", drw_rdata, 16'hA000 + 16'(i));
    end

    // simultaneous requests: VGA first, drawer in 2-3
    wait_slot(3);
    vga_req = 1'b1; vga_addr = 18'h12345; drw_req = 1'b1; drw_we = 1'b0; drw_addr = 18'h00101;
    step(); chk("sim_s0_addr", sram_addr, 18'h12345); chk("sim_s0_oe", sram_oe_n, 0); chk("sim_s0_ack", drw_ack, 0);
    step(); chk("sim_s1_addr", sram_addr, 18'h12345); chk("sim_s1_ack", drw_ack, 0);
    step(); chk("sim_s2_addr", sram_addr, 18'h00101); chk("sim_s2_ack", drw_ack, 0); chk("sim_s2_valid", vga_valid, 1);
    step(); chk("sim_s3_ack", drw_ack, 1);
    drw_req = 1'b0;
    step(); chk("sim_rdata", drw_rdata, 16'hA001); chk("sim_s0_vga", sram_addr, 18'h12345);

    // frame_align during write setup aborts and retries
    drw_req = 1'b1; drw_we = 1'b1; drw_addr = 18'h000B0; drw_wdata = 16'h5A5A; wbase = wr_cnt;
    wait_slot(2);
    chk("fa_c1_we", {sram_ce_n, sram_we_n}, 2'b01); chk("fa_c1_dq", sram_dq, 16'h5A5A);
    frame_align = 1'b1;
    step(); frame_align = 1'b0;
    chk("fa_abort_pins", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111); chk("fa_abort_ack", drw_ack, 0);
    chk("fa_abort_dq_z", sram_dq === 16'hzzzz, 1);
    step(); chk("fa_s1_ack", drw_ack, 0); chk("fa_s1_we", sram_we_n, 1);
    step(); chk("fa_retry_c1", {sram_ce_n, sram_we_n}, 2'b01); chk("fa_retry_addr", sram_addr, 18'h000B0);
    step(); chk("fa_retry_we", sram_we_n, 0); chk("fa_retry_ack", drw_ack, 1);
    drw_req = 1'b0;
    step(); chk("fa_mem", mem[18'h000B0], 16'h5A5A); chk("fa_wr_count", wr_cnt - wbase, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
